uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and defaults for the UART transmitter.
//   tx_state_e           : transmit FSM states (IDLE, START, DATA, STOP)
//   CLKS_PER_BIT_DEFAULT : 434 clocks per bit (50 MHz / 115200 baud)
//   FIFO_DEPTH_DEFAULT   : 4 queued bytes
//   line_level()         : serial line level for a given state and data bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int FIFO_DEPTH_DEFAULT   = 4;

  // 8N1 framing: start bit low, data LSB first, stop bit and idle high.
  function automatic logic line_level(input tx_state_e st, input logic data_bit);
    case (st)
      START:   return 1'b0;
      DATA:    return data_bit;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte handshake between a producer and the UART transmitter.
//   tx_data  : byte offered by the producer
//   tx_valid : producer offers tx_data this cycle
//   tx_ready : transmitter can accept a byte this cycle
// modport master = producer side, modport slave = transmitter side.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// tx_fifo -- byte FIFO feeding the UART shift register.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push,din : write din when push and not full
//   pop,dout : dout shows the head; pop removes it when not empty
//   full, empty, count : occupancy status (count is exact on push+pop)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a small byte FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   tx_if      : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx         : registered serial line, idle high
//   busy       : a frame is in progress or bytes are queued
//   fifo_count : queued bytes, not counting the byte being shifted
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_if.slave                      tx_if,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q;
  logic          pop;
  logic          baud_end;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;

  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_if.tx_valid),
    .din   (tx_if.tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready is a pure function of occupancy; a pop in the same cycle does not
  // open a slot early, which keeps tx_ready free of any FSM timing path.
  assign tx_if.tx_ready = !fifo_full;
  assign busy           = (state_q != IDLE) || (fifo_count != '0);
  assign tx             = tx_q;
  assign baud_end       = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames abut.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is a flop fed from the current state, so the line trails the FSM by
  // one clock: a pop at edge N+1 shows the start bit after edge N+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= line_level(state_q, shift_q[0]);
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- scoreboard bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are queued by the driver; a receiver model on tx pops and
// compares every completed frame. Directed timing checks run alongside.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_if      (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int         n_run = 0;
  int         n_fail = 0;
  int         frames_rx = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clock of handshake; called #1 after a rising edge, returns #1 after
  // the next one. The accepted byte becomes an expected frame.
  task automatic cycle_push(input logic v, input logic [7:0] d, output logic acc);
    bus.tx_valid = v;
    bus.tx_data  = d;
    @(negedge clk);
    acc = v & bus.tx_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  // Called on the first cycle of a start bit; compares the line cycle by
  // cycle against hand-built 8N1 frames and checks busy stays high until
  // the last cycle of the last stop bit.
  task automatic watch_frames(input int nf, input logic [7:0] b0, input logic [7:0] b1,
                              input string name);
    int         line_err;
    int         busy_err;
    int         pos;
    logic [7:0] b;
    logic       exp_bit;
    logic       exp_busy;
    line_err = 0;
    busy_err = 0;
    for (int i = 0; i < FRAME * nf; i++) begin
      b   = (i < FRAME) ? b0 : b1;
      pos = (i % FRAME) / CPB;
      if (pos == 0)      exp_bit = 1'b0;
      else if (pos == 9) exp_bit = 1'b1;
      else               exp_bit = b[pos-1];
      exp_busy = (i != FRAME * nf - 1);
      if (tx !== exp_bit)    line_err++;
      if (busy !== exp_busy) busy_err++;
      tick(1);
    end
    check({name, "_line_errs"}, line_err, 0);
    check({name, "_busy_errs"}, busy_err, 0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_idle_timeout"}, busy, 1'b0);
    tick(4);
  endtask

  // Reference receiver: start detected on a falling-edge sample, each bit
  // sampled mid-bit; a reset seen during the frame drops it.
  initial begin : monitor
    logic [7:0] d;
    logic [7:0] e;
    logic       st;
    logic       sp;
    logic       ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        ab = 1'b0; st = 1'b1; sp = 1'b0; d = 8'h00;
        for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
          if (k == CPB / 2) st = tx;
          else if (k >= CPB + CPB / 2 && k <= 8 * CPB + CPB / 2 && ((k - CPB / 2) % CPB) == 0)
            d[(k - CPB / 2) / CPB - 1] = tx;
          else if (k == 9 * CPB + CPB / 2) sp = tx;
        end
        if (!ab) begin
          frames_rx++;
          if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL rx_unexpected: got frame 0x%0h, required no frame", d);
          end else begin
            e = exp_q.pop_front();
            // {start, stop, data} must read {0, 1, expected byte}
            check("rx_frame", {22'b0, st, sp, d}, {22'b0, 1'b0, 1'b1, e});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic       acc;
    logic [5:0] accv;
    logic [31:0] cntpk;
    int         peak;
    int         idle_err;
    int         n_acc;
    int         cyc;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", bus.tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    tick(1);
    rst = 1'b0;

    // Single 0xA5 from idle, pushed on the first edge after reset release.
    cycle_push(1'b1, 8'hA5, acc);
    check("first_push_after_rst", acc, 1'b1);
    check("a5_count_after_push", fifo_count, 1);
    tick(1);
    check("a5_tx_high_at_pop", tx, 1'b1);
    check("a5_count_after_pop", fifo_count, 0);
    tick(1);
    watch_frames(1, 8'hA5, 8'h00, "a5");
    check("a5_tx_idle", tx, 1'b1);
    tick(4);

    // 0x00 then 0xFF back to back.
    cycle_push(1'b1, 8'h00, acc);
    check("b2b_push0", acc, 1'b1);
    cycle_push(1'b1, 8'hFF, acc);
    check("b2b_push1", acc, 1'b1);
    check("b2b_count_push_pop", fifo_count, 1);
    tick(1);
    watch_frames(2, 8'h00, 8'hFF, "b2b");
    tick(4);

    // Six consecutive pushes: five fit (one shifting + four queued).
    accv  = '0;
    cntpk = '0;
    peak  = 0;
    for (int i = 0; i < 6; i++) begin
      cycle_push(1'b1, 8'h10 + 8'(i), acc);
      accv[i] = acc;
      cntpk   = cntpk | (32'(fifo_count) << (4 * i));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("six_accept_vec", accv, 6'b011111);
    check("six_count_trace", cntpk, 32'h0044_3211);
    check("six_count_peak", peak, 4);
    // First frame popped on the 2nd push edge; its stop bit ends 40 edges
    // later, which is 36 edges after the 6th push edge.
    tick(35);
    check("full_count_before_pop", fifo_count, 4);
    cycle_push(1'b1, 8'hEE, acc);
    check("full_push_on_pop_rejected", acc, 1'b0);
    check("ready_after_pop", bus.tx_ready, 1'b1);
    check("count_after_pop", fifo_count, 3);
    wait_idle(400, "six");

    // Reset during data bit 3 of 0x31 (bit 3 = 0) with two bytes queued.
    cycle_push(1'b1, 8'h31, acc);
    cycle_push(1'b1, 8'h32, acc);
    cycle_push(1'b1, 8'h33, acc);
    tick(16);
    check("rst_mid_queued", fifo_count, 2);
    check("rst_mid_tx_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", bus.tx_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
      tick(1);
    end
    check("post_rst_no_frame", idle_err, 0);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    cycle_push(1'b1, 8'h5A, acc);
    check("push_after_rst_release", acc, 1'b1);
    wait_idle(200, "post_rst");

    // 200 accepted bytes with random gaps against the receiver model.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 200 && cyc < 20000) begin
      cycle_push(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), acc);
      if (acc) n_acc++;
      cyc++;
    end
    check("rand_accepted", n_acc, 200);
    wait_idle(2000, "rand");
    check("rand_drained", exp_q.size(), 0);
    check("rx_frame_total", frames_rx, 1 + 2 + 5 + 1 + 200);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
